uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a configurable frame format (data width, parity, stop bits), per-frame error detection and a receive FIFO. It presents received words on a valid/ready stream. It is the next-generation receive front end for the `Primario` top level, one instance per serial port (`rxd`, `rxd_B`). It replaces the fixed 8N1 receiver and adds parity checking, error flags and buffering, so the PicoRV32 side can service ports in bursts.

## Interface
- `PRESCALE`, 1302: clock cycles per 1/8 bit period. Bit period is `8*PRESCALE` (1302 at 100 MHz gives 9600 baud).
- `DATA_BITS`, 8: data bits per frame. Legal range is 5..9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame. Legal values are 1 and 2.
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk` in 1: system clock. The only clock.
- `rst` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input. Asynchronous to `clk`; idle high.
- `m_tdata` out DATA_BITS: oldest FIFO word (first received bit is the LSB).
- `m_tvalid` out 1: FIFO non-empty.
- `m_tready` in 1: consumer accepts `m_tdata`.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of words held.
- `busy` out 1: receiver is not in IDLE.
- `parity_error` out 1: one-cycle pulse; frame dropped for bad parity.
- `frame_error` out 1: one-cycle pulse; a stop bit sampled low.
- `break_detect` out 1: one-cycle pulse; frame_error with all data bits and parity 0.
- `overrun_error` out 1: one-cycle pulse; good frame dropped because the FIFO was full.

## Operation
- `rxd` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rxs`.
- Bit timer: a down-counter of width $clog2(8*PRESCALE).
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- IDLE: on `rxs`=0, load the timer with 4*PRESCALE-1 and go to START.
- START: at timer expiry, sample `rxs`.
  - 1: false start; go to IDLE with no flag.
  - 0: reload 8*PRESCALE-1 and go to DATA.
- DATA: at each expiry, shift `rxs` in LSB-first and reload. After DATA_BITS samples, go to PAR (PARITY≠0) or STOP.
- PAR: sample the parity bit.
  - Odd: XOR of data and parity must be 1.
  - Even: XOR of data and parity must be 0.
- STOP: sample STOP_BITS bits, 8*PRESCALE apart. On the last sample, decide the frame:
  - Any stop bit 0: pulse `frame_error`. Also pulse `break_detect` if data and parity are all 0. No push; go to WAIT_IDLE.
  - Else parity bad: pulse `parity_error`, no push, go to IDLE.
  - Else FIFO full and no pop this cycle: pulse `overrun_error`, drop the word, go to IDLE.
  - Else push the word and go to IDLE.
- Priority when several apply: frame > parity > overrun. Only one error pulse fires per frame; `break_detect` accompanies `frame_error`.
- WAIT_IDLE: stay until `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering as a stream of frames.
- The FSM returns to IDLE at the centre of the last stop bit. A start edge arriving immediately after is accepted.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the index.
  - Pop when `m_tvalid && m_tready`.
  - Simultaneous push and pop when full is legal: the pop frees the slot and the level stays FIFO_DEPTH.
  - Simultaneous push and pop when empty is impossible, because valid is low.
  - `m_tdata` is `mem[rd_ptr]`, read combinationally. It is stable while `m_tvalid` is high and not popped.
- Reset (asynchronous assert, synchronous release):
  - FSM to IDLE and FIFO emptied.
  - `m_tvalid`=0, `fifo_level`=0, `busy`=0, all error pulses 0, `m_tdata`=0.
  - Reset in the middle of a frame discards the partial frame.
  - If `rxd` is still low at release, the remainder of that frame is treated as a new start (false-start logic applies).

## Timing
- Take cycle 0 as the first `clk` edge at which `rxd`=0 is registered. `rxs` falls at cycle 2.
- Start-bit sample at cycle 2+4*PRESCALE.
- Sample k (k=1.. for data, then parity, then stop) at cycle 2+4*PRESCALE+8*PRESCALE*k. Bench tolerance is ±2 cycles.
- Push and error pulses occur in the cycle after the last stop sample.
- `m_tvalid` and `fifo_level` update one cycle after the push. There is no fall-through.
- `busy` rises in the cycle after `rxs` falls in IDLE. It falls when the FSM re-enters IDLE.
- Throughput is one frame per frame time. The FIFO absorbs at most FIFO_DEPTH words with `m_tready` held low.

## Test plan
1. 8N1, PRESCALE=1302. Stimulus: frame bits 0,1,1,1,1,1,0,1 LSB-first, bit time 104167 ns, `m_tready`=1. Required: `m_tdata`=0xBE with `m_tvalid` for one cycle; no error pulses.
2. PARITY=2, PRESCALE=4. Stimulus: 0xA5 with correct parity bit 0, then 0xA5 with parity bit 1. Required: first frame pushed; second gives a single `parity_error` pulse; `fifo_level` is 1.
3. PRESCALE=4. Stimulus: `rxd` held low for 12 bit times, then high. Required: one `frame_error` and one `break_detect` pulse; no push; `busy` stays high until `rxd` returns high.
4. FIFO_DEPTH=4, `m_tready`=0. Stimulus: send 0x01..0x05. Required: `fifo_level`=4 and `overrun_error` on the fifth frame. Then with `m_tready`=1, the reads return 0x01, 0x02, 0x03, 0x04.
5. Stimulus: a 2*PRESCALE-cycle low glitch on an idle line. Required: false start; `busy` pulses, then returns to IDLE; no push and no error.
6. Stimulus: assert `rst` low in the middle of a data bit of 0x3C, release, then send 0x5A. Required: all outputs at their reset values during reset; only 0x5A is received.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, per-frame error flags and a
// receive FIFO presented on a valid/ready stream.
module uart_rx_fifo #(
  parameter int unsigned PRESCALE   = 1302,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          parity_error,
  output logic                          frame_error,
  output logic                          break_detect,
  output logic                          overrun_error
);

  localparam int unsigned TW = $clog2(8 * PRESCALE);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_HALF    = TW'(4 * PRESCALE - 1);
  localparam logic [TW-1:0] T_BIT     = TW'(8 * PRESCALE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

  logic                 rxd_meta, rxs;
  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 stop_ok_q, stop_ok_d;
  logic                 push_q, push_d;
  logic                 perr_d, ferr_d, brk_d, ovr_d;
  logic                 tick, parity_ok, good_stop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      par_q         <= 1'b0;
      stop_ok_q     <= 1'b1;
      push_q        <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      break_detect  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      par_q         <= par_d;
      stop_ok_q     <= stop_ok_d;
      push_q        <= push_d;
      parity_error  <= perr_d;
      frame_error   <= ferr_d;
      break_detect  <= brk_d;
      overrun_error <= ovr_d;
    end
  end

  assign tick      = (timer_q == '0);
  assign good_stop = stop_ok_q & rxs;

  always_comb begin
    case (PARITY)
      1:       parity_ok = (^{shreg_q, par_q}) == 1'b1;
      2:       parity_ok = (^{shreg_q, par_q}) == 1'b0;
      default: parity_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    stop_ok_d = stop_ok_q;
    push_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;
    ovr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          timer_d = T_HALF;
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else if (rxs) begin
          state_d = IDLE;
        end else begin
          timer_d = T_BIT;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          timer_d = T_BIT;
          if (cnt_q == LAST_DATA) begin
            cnt_d     = '0;
            par_d     = 1'b0;
            stop_ok_d = 1'b1;
            state_d   = (PARITY != 0) ? PAR : STOP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else begin
          par_d   = rxs;
          timer_d = T_BIT;
          state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else if (cnt_q != LAST_STOP) begin
          stop_ok_d = good_stop;
          cnt_d     = cnt_q + 4'd1;
          timer_d   = T_BIT;
        end else if (!good_stop) begin
          // Frame beats parity beats overrun; a low line must go high before re-arming.
          ferr_d  = 1'b1;
          brk_d   = (shreg_q == '0) && !par_q;
          state_d = WAIT_IDLE;
        end else if (!parity_ok) begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end else if (full && !pop) begin
          ovr_d   = 1'b1;
          state_d = IDLE;
        end else begin
          push_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // The shift register holds the word through the push cycle: a new frame
  // cannot shift data until well after its start-bit sample.
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == DEPTH_L);
  assign m_tvalid   = (fifo_level != '0);
  assign pop        = m_tvalid && m_tready;
  assign m_tdata    = m_tvalid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_q) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_q) mem[wr_ptr[AW-1:0]] <= shreg_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 8E1 frames at PRESCALE=4 with a 4-deep FIFO.
module tb_uart_rx_fifo;

  localparam int unsigned P     = 4;
  localparam int unsigned BIT   = 8 * P;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic [2:0] fifo_level;
  logic       busy, parity_error, frame_error, break_detect, overrun_error;

  uart_rx_fifo #(
    .PRESCALE   (P),
    .DATA_BITS  (8),
    .PARITY     (2),
    .STOP_BITS  (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .fifo_level    (fifo_level),
    .busy          (busy),
    .parity_error  (parity_error),
    .frame_error   (frame_error),
    .break_detect  (break_detect),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_perr = 0, n_ferr = 0, n_brk = 0, n_ovr = 0;
  int unsigned cyc = 0, start_cyc = 0, valid_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (parity_error)  n_perr++;
      if (frame_error)   n_ferr++;
      if (break_detect)  n_brk++;
      if (overrun_error) n_ovr++;
      if (m_tvalid && !prev_valid) valid_cyc = cyc;
      if (m_tvalid && m_tready) begin
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check("pop_data", m_tdata, exp_word);
        end
      end
    end
    prev_valid = m_tvalid;
  end

  task automatic send(input logic [7:0] d, input logic pbit);
    @(negedge clk);
    start_cyc = cyc;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = pbit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send(d, ^d);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 * BIT; i++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      @(negedge clk);
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_tvalid, 0);
    check({tag, "_level"},  fifo_level, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_tdata"},  m_tdata, 0);
    check({tag, "_pulses"}, {parity_error, frame_error, break_detect, overrun_error}, 0);
  endtask

  initial begin
    int unsigned lat;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame, consumer ready; also latency from first low edge to m_tvalid.
    m_tready = 1'b1;
    send_good(8'hBE);
    wait_drain("t1_drain");
    lat = valid_cyc - start_cyc;
    check("t1_latency_in_window", (lat >= 338 && lat <= 342), 1);
    check("t1_no_errors", n_perr + n_ferr + n_brk + n_ovr, 0);

    // Even parity: correct then flipped parity bit.
    m_tready = 1'b0;
    send_good(8'hA5);
    send(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("t2_level", fifo_level, 1);
    check("t2_tdata", m_tdata, 8'hA5);
    check("t2_parity_errs", n_perr, 1);
    m_tready = 1'b1;
    wait_drain("t2_drain");

    // Break: line held low for 12 bit times.
    @(negedge clk);
    rxd = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("t3_busy_held", busy, 1);
    check("t3_frame_errs", n_ferr, 1);
    check("t3_breaks", n_brk, 1);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_busy_released", busy, 0);
    check("t3_level", fifo_level, 0);
    check("t3_parity_errs", n_perr, 1);

    // Overrun on the fifth frame with the consumer stalled.
    m_tready = 1'b0;
    for (int d = 1; d <= 4; d++) send_good(8'(d));
    send(8'h05, ^8'h05);
    repeat (4) @(negedge clk);
    check("t4_level_full", fifo_level, DEPTH);
    check("t4_overruns", n_ovr, 1);
    check("t4_frame_errs", n_ferr, 1);
    m_tready = 1'b1;
    wait_drain("t4_drain");

    // Glitch shorter than half a bit: false start.
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_glitch", busy, 1);
    repeat (2 * P - 4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_busy_idle", busy, 0);
    check("t5_level", fifo_level, 0);
    check("t5_error_total", n_perr + n_ferr + n_brk + n_ovr, 4);

    // Reset mid-frame with a word already buffered.
    m_tready = 1'b0;
    send_good(8'h11);
    check("t6_level_before", fifo_level, 1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = ((8'h3C >> i) & 8'h01) != 0;
      repeat (BIT) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("t6_busy_mid", busy, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst_now");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_rst_held");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    m_tready = 1'b1;
    send_good(8'h5A);
    wait_drain("t6_drain");
    check("t6_error_total", n_perr + n_ferr + n_brk + n_ovr, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
